gam_recall_controller: RTL

Recall-side sequencer for the GAM memory layer. While the learning controller writes node weights and classes, this block reads them back. It accepts a query vector one element at a time, then scans every stored node element by element and accumulates the squared Euclidean distance to each node. It then reports the nearest node, its class and its distance through a valid/ack result handshake. It sits beside the learning controller on the same node-memory read port and is enabled when the top level selects RECALL.

---
 rtl/gam_recall_controller.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gam_recall_controller.sv
// gam_recall_controller
// Recall-side sequencer for the GAM memory layer: loads a query vector, scans
// every stored node through the shared node-memory read port, accumulates the
// squared Euclidean distance per node and reports the nearest node.
// Optional feature macro: GAM_RECALL_THRESHOLD_EN (adds recall_th / result_unknown).
module gam_recall_controller #(
    parameter int DATA_W  = 8,
    parameter int DIM     = 4,
    parameter int NODE_AW = 4,
    parameter int CLASS_W = 4,
    localparam int EAW    = $clog2(DIM),
    localparam int DIST_W = 2 * DATA_W + EAW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   recall_start,
    input  logic [NODE_AW:0]       node_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   mem_rd_en,
    output logic [NODE_AW+EAW-1:0] mem_addr,
    input  logic [DATA_W-1:0]      mem_rd_data,
    input  logic [CLASS_W-1:0]     cls_rd_data,
`ifdef GAM_RECALL_THRESHOLD_EN
    input  logic [DIST_W-1:0]      recall_th,
    output logic                   result_unknown,
`endif
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ack,
    output logic                   result_empty,
    output logic [NODE_AW-1:0]     result_node,
    output logic [CLASS_W-1:0]     result_class,
    output logic [DIST_W-1:0]      result_dist
);

    localparam int SQ_W = 2 * DATA_W + 2;
    localparam logic [EAW-1:0] LAST_ELEM = EAW'(DIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        FIN,
        RESULT
    } state_t;

    state_t               state_reg, state_next;
    logic [EAW-1:0]       elem_reg, elem_next;
    logic [NODE_AW-1:0]   node_reg, node_next;
    logic [NODE_AW:0]     count_reg, count_next;
    logic [DIST_W-1:0]    acc_reg, acc_next;
    logic [DIST_W-1:0]    min_dist_reg, min_dist_next;
    logic [NODE_AW-1:0]   min_node_reg, min_node_next;
    logic [CLASS_W-1:0]   min_class_reg, min_class_next;
    logic                 res_empty_reg, res_empty_next;
    logic [NODE_AW-1:0]   res_node_reg, res_node_next;
    logic [CLASS_W-1:0]   res_class_reg, res_class_next;
    logic [DIST_W-1:0]    res_dist_reg, res_dist_next;
`ifdef GAM_RECALL_THRESHOLD_EN
    logic [DIST_W-1:0]    th_reg, th_next;
    logic                 res_unknown_reg, res_unknown_next;
`endif

    // Query buffer and its registered read port (element issued last cycle)
    logic [DATA_W-1:0]    qbuf_reg [DIM];
    logic [DATA_W-1:0]    q_pend_reg;

    logic                 load_fire;
    logic signed [DATA_W:0] diff;
    logic signed [SQ_W-1:0] diff_ext;
    logic signed [SQ_W-1:0] sq;
    logic [DIST_W-1:0]    term;
    logic [DIST_W-1:0]    dist_sum;
    logic                 last_node;

    assign load_fire = (state_reg == LOAD) && in_valid;
    assign last_node = ({1'b0, node_reg} == (count_reg - 1'b1));

    // Each query element lands in its own slot, selected by the element counter
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_qbuf
            always_ff @(posedge clk) begin
                if (load_fire && (elem_reg == EAW'(gi))) begin
                    qbuf_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    // Read the query element alongside the memory request so both arrive together
    always_ff @(posedge clk) begin
        q_pend_reg <= qbuf_reg[elem_reg];
    end

    // Squared difference of the returning weight against its query element
    always_comb begin
        diff     = $signed({1'b0, q_pend_reg}) - $signed({1'b0, mem_rd_data});
        diff_ext = SQ_W'(diff);
        sq       = diff_ext * diff_ext;
        term     = DIST_W'($unsigned(sq));
        dist_sum = acc_reg + term;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            elem_reg      <= '0;
            node_reg      <= '0;
            count_reg     <= '0;
            acc_reg       <= '0;
            min_dist_reg  <= '1;
            min_node_reg  <= '0;
            min_class_reg <= '0;
            res_empty_reg <= 1'b0;
            res_node_reg  <= '0;
            res_class_reg <= '0;
            res_dist_reg  <= '0;
`ifdef GAM_RECALL_THRESHOLD_EN
            th_reg          <= '0;
            res_unknown_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            elem_reg      <= elem_next;
            node_reg      <= node_next;
            count_reg     <= count_next;
            acc_reg       <= acc_next;
            min_dist_reg  <= min_dist_next;
            min_node_reg  <= min_node_next;
            min_class_reg <= min_class_next;
            res_empty_reg <= res_empty_next;
            res_node_reg  <= res_node_next;
            res_class_reg <= res_class_next;
            res_dist_reg  <= res_dist_next;
`ifdef GAM_RECALL_THRESHOLD_EN
            th_reg          <= th_next;
            res_unknown_reg <= res_unknown_next;
`endif
        end
    end

    // Next-state and datapath update for the recall sequence
    always_comb begin
        state_next     = state_reg;
        elem_next      = elem_reg;
        node_next      = node_reg;
        count_next     = count_reg;
        acc_next       = acc_reg;
        min_dist_next  = min_dist_reg;
        min_node_next  = min_node_reg;
        min_class_next = min_class_reg;
        res_empty_next = res_empty_reg;
        res_node_next  = res_node_reg;
        res_class_next = res_class_reg;
        res_dist_next  = res_dist_reg;
`ifdef GAM_RECALL_THRESHOLD_EN
        th_next          = th_reg;
        res_unknown_next = res_unknown_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (recall_start) begin
                    count_next = node_count;
                    elem_next  = '0;
                    state_next = LOAD;
`ifdef GAM_RECALL_THRESHOLD_EN
                    th_next    = recall_th;
`endif
                end
            end
            LOAD: begin
                if (in_valid) begin
                    elem_next = elem_reg + 1'b1;
                    if (elem_reg == LAST_ELEM) begin
                        elem_next = '0;
                        if (count_reg == '0) begin
                            state_next     = RESULT;
                            res_empty_next = 1'b1;
                            res_node_next  = '0;
                            res_class_next = '0;
                            res_dist_next  = '0;
`ifdef GAM_RECALL_THRESHOLD_EN
                            res_unknown_next = 1'b1;
`endif
                        end else begin
                            state_next     = SCAN;
                            node_next      = '0;
                            acc_next       = '0;
                            min_dist_next  = '1;
                            min_node_next  = '0;
                            min_class_next = '0;
                        end
                    end
                end
            end
            SCAN: begin
                // Element 0 has no returning data yet; later cycles fold in e-1
                if (elem_reg != '0) begin
                    acc_next = dist_sum;
                end
                elem_next = elem_reg + 1'b1;
                if (elem_reg == LAST_ELEM) begin
                    elem_next  = '0;
                    state_next = FIN;
                end
            end
            FIN: begin
                acc_next = '0;
                // Strict compare keeps the earliest node on a tie
                if (dist_sum < min_dist_reg) begin
                    min_dist_next  = dist_sum;
                    min_node_next  = node_reg;
                    min_class_next = cls_rd_data;
                end
                if (last_node) begin
                    state_next     = RESULT;
                    res_empty_next = 1'b0;
                    res_node_next  = min_node_next;
                    res_class_next = min_class_next;
                    res_dist_next  = min_dist_next;
`ifdef GAM_RECALL_THRESHOLD_EN
                    res_unknown_next = (min_dist_next > th_reg);
`endif
                end else begin
                    node_next  = node_reg + 1'b1;
                    elem_next  = '0;
                    state_next = SCAN;
                end
            end
            RESULT: begin
                if (result_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from state and counters
    always_comb begin
        busy         = (state_reg != IDLE);
        in_ready     = (state_reg == LOAD);
        mem_rd_en    = (state_reg == SCAN);
        mem_addr     = (state_reg == SCAN) ? {node_reg, elem_reg} : '0;
        result_valid = (state_reg == RESULT);
        result_empty = res_empty_reg;
        result_node  = res_node_reg;
        result_class = res_class_reg;
        result_dist  = res_dist_reg;
`ifdef GAM_RECALL_THRESHOLD_EN
        result_unknown = res_unknown_reg;
`endif
    end

endmodule
